// File: rtl/alink_dispatch.sv
// alink_dispatch: waits for one complete job in the TX FIFO, grants it to the next idle,
// enabled channel in round-robin order and streams its words over valid/ready.
module alink_dispatch #(
    parameter int unsigned CH_NUM    = 32,
    parameter int unsigned CH_W      = 5,
    parameter int unsigned JOB_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       txcnt,
    input  logic [31:0]       txfifo_dout,
    output logic              txfifo_pop,
    input  logic              reg_flush,
    input  logic [CH_NUM-1:0] reg_mask,
    input  logic [CH_NUM-1:0] busy,
    output logic [CH_W-1:0]   ch_sel,
    output logic              ch_valid,
    output logic [31:0]       ch_data,
    output logic              ch_last,
    input  logic              ch_ready,
    output logic              ch_abort,
    output logic              job_done,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArb  = 2'd1,
        StSend = 2'd2,
        StDone = 2'd3
    } state_e;

    state_e            state_q;
    logic [7:0]        cnt_q;
    logic [CH_W-1:0]   ch_sel_q;
    logic [CH_W-1:0]   last_grant_q;
    logic              abort_q;

    logic [CH_NUM-1:0] eligible;
    logic              job_ready;
    logic              send;
    logic              last_word;
    logic [CH_W-1:0]   pick;
    logic [CH_W-1:0]   cand;
    logic              found;

    assign eligible  = reg_mask & ~busy;
    assign job_ready = (txcnt >= 11'(JOB_WORDS)) & (|eligible);
    assign send      = (state_q == StSend);
    assign last_word = (cnt_q == 8'(JOB_WORDS - 1));

    // Round-robin pick: first eligible channel strictly after the last completed grant.
    always_comb begin
        pick  = last_grant_q;
        cand  = last_grant_q;
        found = 1'b0;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
            cand = (cand == CH_W'(CH_NUM - 1)) ? '0 : cand + 1'b1;
            if (!found && eligible[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Outputs decoded from registered state; flush blocks the pop in the same cycle.
    always_comb begin
        ch_valid   = send;
        ch_data    = send ? txfifo_dout : '0;
        ch_last    = send & last_word;
        txfifo_pop = send & ch_ready & ~reg_flush;
        ch_sel     = ch_sel_q;
        ch_abort   = abort_q;
        job_done   = (state_q == StDone);
        state_o    = state_q;
    end

    // Scheduler FSM: IDLE -> ARB -> SEND (JOB_WORDS beats) -> DONE -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            ch_sel_q     <= '0;
            last_grant_q <= CH_W'(CH_NUM - 1);
            abort_q      <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (job_ready && !reg_flush) begin
                        state_q <= StArb;
                    end
                end
                StArb: begin
                    // Eligibility is re-sampled here; it may have vanished since IDLE.
                    if (reg_flush || (eligible == '0)) begin
                        state_q <= StIdle;
                    end else begin
                        ch_sel_q <= pick;
                        cnt_q    <= '0;
                        state_q  <= StSend;
                    end
                end
                StSend: begin
                    if (reg_flush) begin
                        // Truncated job: no grant history update, no job_done.
                        abort_q <= 1'b1;
                        state_q <= StIdle;
                    end else if (ch_ready) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (last_word) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    last_grant_q <= ch_sel_q;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/alink_dispatch.md
Name: alink_dispatch

Overview:
- Job scheduler between the ALINK TX FIFO and the per-chip serial channels.
- Waits until the TX FIFO holds one complete job of JOB_WORDS words.
- Selects the next idle, unmasked channel in round-robin order and streams that job's words to it over a valid/ready handshake.
- Sits between the ALINK wishbone slave's mask/busy/flush registers and the channel transmitters.

Parameters:
- CH_NUM, 32, number of downstream channels (2..32).
- CH_W, 5, width of the channel index; must satisfy 2^CH_W >= CH_NUM.
- JOB_WORDS, 8, 32-bit words per job (2..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- txcnt  in  11  TX FIFO occupancy in words.
- txfifo_dout  in  32  TX FIFO head word; first-word-fall-through, valid whenever txcnt != 0.
- txfifo_pop  out  1  pops the TX FIFO head this cycle.
- reg_flush  in  1  one-cycle flush pulse from the state register.
- reg_mask  in  CH_NUM  1 = channel enabled.
- busy  in  CH_NUM  1 = channel currently hashing.
- ch_sel  out  CH_W  index of the target channel.
- ch_valid  out  1  ch_data valid.
- ch_data  out  32  job word.
- ch_last  out  1  marks the final word of a job; qualified by ch_valid.
- ch_ready  in  1  selected channel accepts the word.
- ch_abort  out  1  one-cycle pulse: the job on ch_sel was truncated.
- job_done  out  1  one-cycle pulse: a job completed.
- state_o  out  2  FSM state for debug: 0 IDLE, 1 ARB, 2 SEND, 3 DONE.

Behaviour:

Reset values (rst_n low):
- All outputs 0; state IDLE; word counter 0; last_grant = CH_NUM-1, so the first grant is channel 0.

Eligibility and readiness:
- eligible[i] = reg_mask[i] & ~busy[i].
- job_ready = (txcnt >= JOB_WORDS) & (|eligible).

FSM, registered, one transition per clock:
- IDLE -> ARB when job_ready & ~reg_flush.
- ARB, one cycle:
  - Latch ch_sel = the first eligible index scanning last_grant+1, last_grant+2, ..., wrapping modulo CH_NUM.
  - If eligible has gone all-zero, return to IDLE; ch_sel is unchanged.
  - Otherwise go to SEND with word counter = 0.
- SEND:
  - ch_valid = 1 and ch_data = txfifo_dout, both combinational from the FIFO head.
  - ch_last = 1 when counter == JOB_WORDS-1.
  - txfifo_pop = ch_valid & ch_ready; counter increments on each accepted word.
  - Word acceptance is combinational; ch_ready may stay high every cycle, giving 1 word per clock.
  - Accepting the last word moves the FSM to DONE.
- DONE, one cycle: job_done = 1, last_grant <= ch_sel, then IDLE.

Rules:
- busy and reg_mask are sampled only in ARB; changes during SEND are ignored.
- Throughput: a job takes JOB_WORDS + 3 cycles, from the IDLE decision to IDLE again.
- txcnt is never underrun: the full job is present before ARB, and nothing else pops.

Flush handling:
- reg_flush in IDLE or ARB: go to IDLE, no grant.
- reg_flush in SEND: no pop that cycle, even if ch_ready.
  - Next cycle: ch_valid = 0, ch_abort = 1 for one cycle, state IDLE.
  - last_grant is not updated and job_done does not fire.
  - The remaining FIFO words are cleared externally by the flush.
- reg_flush in DONE: DONE completes normally.
- Simultaneous ch_ready and reg_flush in SEND: flush wins; the word is not popped.

Reset mid-job:
- Outputs clear immediately, asynchronously.
- The FIFO is not touched by this block.

Other:
- ch_sel holds its value outside SEND, so it is always stable while ch_valid is high.
- ch_last and txfifo_pop are never asserted outside SEND.

Test Plan:
1. Basic job:
   - Stimulus: reset, mask=0xFFFFFFFF, busy=0, preload 8 words 0x100..0x107, ch_ready=1.
   - Required: ch_sel=0; 8 consecutive ch_valid beats carrying 0x100..0x107; ch_last on 0x107; 8 pops; job_done 1 cycle later; state_o back to 0.
2. Round-robin and skip:
   - Stimulus: 24 words, mask=0x0000000D, busy=0.
   - Required: three jobs granted to channels 0, 2, 3 in that order.
   - Repeat with busy=0x4: grants go 0, 3, 0.
3. Backpressure:
   - Stimulus: ch_ready toggles 1,0,0,1,... during SEND.
   - Required: ch_data is held while ready is low; pops occur only on ready beats; total of exactly 8 pops; the word order is intact.
4. Insufficient data or no channel:
   - Stimulus: txcnt=7 with channels eligible; then txcnt=8 with mask=0.
   - Required: state_o stays 0 and there are no pops.
   - Then set mask=0x1: the job starts on channel 0.
5. Flush mid-job:
   - Stimulus: reg_flush pulses after the 3rd accepted word.
   - Required: exactly 3 pops; ch_abort pulse; no job_done; the next job is granted to the same channel again, since last_grant was not updated.
6. Async reset:
   - Stimulus: assert rst_n=0 during SEND at word 5.
   - Required: ch_valid, txfifo_pop and state_o are 0 within the same cycle; after release the first grant is channel 0.
